hslp_seq_ctrl: RTL

HSLP_SEQ_CTRL -- requirements
Module: hslp_seq_ctrl

---
 rtl/hslp_seq_ctrl_pkg.sv | 46 ++++
 rtl/hslp_seq_ctrl_mul4_sel.sv | 49 ++++
 rtl/hslp_seq_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hslp_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hslp_seq_ctrl_pkg
// Shared definitions for the sequential approximate 8x8 multiplier:
//   - FSM state encodings (IDLE, LL, LH, HL, HH, DONE)
//   - 4x4 multiplier mode encodings (exact, ap1, ap2, ap3)
//   - quadrant shift amounts (LL 0, LH 4, HL 4, HH 8)
//   - next_quad(): picks the next quadrant state to visit given a skip mask
// -----------------------------------------------------------------------------
package hslp_seq_ctrl_pkg;

    // FSM states. Quadrant states are consecutive so that quadrant index i
    // maps to state ST_LL + i.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LL   = 3'd1;
    localparam logic [2:0] ST_LH   = 3'd2;
    localparam logic [2:0] ST_HL   = 3'd3;
    localparam logic [2:0] ST_HH   = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    // 4x4 multiplier modes (2-bit field per quadrant in cfg).
    localparam logic [1:0] MODE_EXACT = 2'd0;
    localparam logic [1:0] MODE_AP1   = 2'd1;
    localparam logic [1:0] MODE_AP2   = 2'd2;
    localparam logic [1:0] MODE_AP3   = 2'd3;

    // Left shift applied to each quadrant's partial product.
    localparam logic [3:0] SHIFT_LL = 4'd0;
    localparam logic [3:0] SHIFT_LH = 4'd4;
    localparam logic [3:0] SHIFT_HL = 4'd4;
    localparam logic [3:0] SHIFT_HH = 4'd8;

    // First quadrant state strictly after 'from' whose skip bit is clear;
    // ST_DONE when none remain. skip[i] belongs to state ST_LL + i.
    function automatic logic [2:0] next_quad(input logic [2:0] from,
                                             input logic [3:0] skip);
        logic [2:0] nxt;
        nxt = ST_DONE;
        for (int i = 3; i >= 0; i--) begin
            if (!skip[i] && ((3'(i) + ST_LL) > from)) begin
                nxt = 3'(i) + ST_LL;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/hslp_seq_ctrl_mul4_sel.sv
// -----------------------------------------------------------------------------
// hslp_seq_ctrl_mul4_sel (module mul4_sel)
// Combinational 4x4 multiplier with selectable approximation.
//   x_i    [3:0]  first operand nibble
//   y_i    [3:0]  second operand nibble
//   mode_i [1:0]  exact / ap1 / ap2 / ap3
//   p_o    [7:0]  product
// Approximations truncate operand LSBs before multiplying:
//   ap1: x LSB forced to 0
//   ap2: x and y LSBs forced to 0
//   ap3: two LSBs of x and y forced to 0
// -----------------------------------------------------------------------------
module mul4_sel
    import hslp_seq_ctrl_pkg::*;
(
    input  logic [3:0] x_i,
    input  logic [3:0] y_i,
    input  logic [1:0] mode_i,
    output logic [7:0] p_o
);

    logic [3:0] xa;
    logic [3:0] ya;

    always_comb begin
        xa = x_i;
        ya = y_i;
        case (mode_i)
            MODE_AP1: begin
                xa = {x_i[3:1], 1'b0};
            end
            MODE_AP2: begin
                xa = {x_i[3:1], 1'b0};
                ya = {y_i[3:1], 1'b0};
            end
            MODE_AP3: begin
                xa = {x_i[3:2], 2'b00};
                ya = {y_i[3:2], 2'b00};
            end
            default: begin
                xa = x_i;
                ya = y_i;
            end
        endcase
    end

    assign p_o = {4'b0000, xa} * {4'b0000, ya};

endmodule

// File: rtl/hslp_seq_ctrl.sv
// -----------------------------------------------------------------------------
// hslp_seq_ctrl
// Sequential approximate 8x8 multiplier: one shared 4x4 multiplier visits the
// quadrants LL, LH, HL, HH (one per cycle) and accumulates into 16 bits.
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   a/b/cfg present          in_ready  high only in IDLE
//   a, b       8-bit operands           cfg       2-bit mode per quadrant
//                                                 [1:0] LL [3:2] LH [5:4] HL [7:6] HH
//   out_valid  high only in DONE        out_ready consumer accepts prod
//   prod       16-bit result, held outside DONE
// Quadrant operands: LL = a[3:0]*b[3:0], LH = a[3:0]*b[7:4],
//                    HL = a[7:4]*b[3:0], HH = a[7:4]*b[7:4].
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready does not depend on in_valid; out_valid stays high with prod
// stable until out_ready is seen, and never drops without a transfer.
// -----------------------------------------------------------------------------
module hslp_seq_ctrl
    import hslp_seq_ctrl_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [7:0]  cfg,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] prod
);

    logic [2:0]  state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [7:0]  cfg_q, cfg_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] prod_q, prod_d;

    logic [3:0]  mx, my;
    logic [1:0]  mmode;
    logic [3:0]  shift_amt;
    logic [7:0]  pp;
    logic [15:0] pp_shifted;

    // Quadrants with a zero nibble contribute nothing, so with SKIP_ZERO they
    // are not visited at all. Bit i corresponds to state ST_LL + i.
    function automatic logic [3:0] skip_vec(input logic [7:0] ma,
                                            input logic [7:0] mb);
        logic [3:0] s;
        s[0] = (ma[3:0] == 4'd0) || (mb[3:0] == 4'd0);
        s[1] = (ma[3:0] == 4'd0) || (mb[7:4] == 4'd0);
        s[2] = (ma[7:4] == 4'd0) || (mb[3:0] == 4'd0);
        s[3] = (ma[7:4] == 4'd0) || (mb[7:4] == 4'd0);
        return SKIP_ZERO ? s : 4'b0000;
    endfunction

    // Operand/mode/shift select for the quadrant being processed.
    always_comb begin
        mx        = a_q[3:0];
        my        = b_q[3:0];
        mmode     = cfg_q[1:0];
        shift_amt = SHIFT_LL;
        case (state_q)
            ST_LH: begin
                mx        = a_q[3:0];
                my        = b_q[7:4];
                mmode     = cfg_q[3:2];
                shift_amt = SHIFT_LH;
            end
            ST_HL: begin
                mx        = a_q[7:4];
                my        = b_q[3:0];
                mmode     = cfg_q[5:4];
                shift_amt = SHIFT_HL;
            end
            ST_HH: begin
                mx        = a_q[7:4];
                my        = b_q[7:4];
                mmode     = cfg_q[7:6];
                shift_amt = SHIFT_HH;
            end
            default: begin
                mx        = a_q[3:0];
                my        = b_q[3:0];
                mmode     = cfg_q[1:0];
                shift_amt = SHIFT_LL;
            end
        endcase
    end

    mul4_sel u_mul4_sel (
        .x_i    (mx),
        .y_i    (my),
        .mode_i (mmode),
        .p_o    (pp)
    );

    assign pp_shifted = {8'h00, pp} << shift_amt;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cfg_d   = cfg_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    cfg_d   = cfg;
                    acc_d   = 16'h0000;
                    state_d = next_quad(ST_IDLE, skip_vec(a, b));
                    // Everything skipped: result is the cleared accumulator.
                    if (state_d == ST_DONE) begin
                        prod_d = 16'h0000;
                    end
                end
            end
            ST_LL, ST_LH, ST_HL, ST_HH: begin
                acc_d   = acc_q + pp_shifted;   // wraps modulo 2^16
                state_d = next_quad(state_q, skip_vec(a_q, b_q));
                // prod only changes when a result is published.
                if (state_d == ST_DONE) begin
                    prod_d = acc_d;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            cfg_q   <= 8'h00;
            acc_q   <= 16'h0000;
            prod_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cfg_q   <= cfg_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign prod      = prod_q;

endmodule
